uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive buffer directly downstream of the UART receiver top. It captures each received byte on the receiver's single-cycle valid pulse, stores it with a per-byte parity-error flag, and presents it to the host side through a pop interface with one-cycle read latency. It also reports full/empty/fill level and a sticky overrun flag for bytes lost when the buffer is full.

## Interface
Parameters:
- DEPTH, 16 — number of entries; power of two, 4..256.

Ports:
- clk  in  1  — system clock; all logic on rising edge.
- reset  in  1  — asynchronous, active-low reset.
- rx_data  in  8  — received byte from the receiver's data_out.
- rx_valid  in  1  — one-cycle strobe from the receiver's valid_out; push request.
- rx_parity_ok  in  1  — receiver's parity_ok, sampled with rx_valid.
- rd_en  in  1  — host pop request.
- clear  in  1  — synchronous flush.
- rd_data  out  8  — popped byte.
- rd_parity_err  out  1  — parity error flag of the popped byte.
- rd_valid  out  1  — rd_data/rd_parity_err valid this cycle.
- empty  out  1  — no stored entries.
- full  out  1  — DEPTH entries stored.
- count  out  $clog2(DEPTH)+1  — current fill level, 0..DEPTH.
- overrun  out  1  — sticky: a push was dropped.
- irq_thresh  in  $clog2(DEPTH)+1  — fill threshold; present only with UART_RX_FIFO_IRQ_EN.
- irq  out  1  — level interrupt; present only with UART_RX_FIFO_IRQ_EN.

## Operation
- Storage: DEPTH entries of 9 bits, {parity_err = ~rx_parity_ok, data}.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH)+1 bits. The low bits index storage and the MSB is the wrap bit. empty = (wr_ptr == rd_ptr). full = index bits equal and wrap bits differ. count = wr_ptr - rd_ptr, computed modulo 2^($clog2(DEPTH)+1).
- Push accepted when rx_valid && (!full || pop_ok). pop_ok = rd_en && !empty.
- Pop accepted when pop_ok. An rd_en while empty is ignored; it does not affect rd_valid or any other state.
- Push while full and with no accepted pop: the byte is dropped, the pointers are unchanged, and overrun is set to 1.
- Simultaneous push and pop:
  - When full: both accepted, count unchanged.
  - When empty: push only.
  - Otherwise: both accepted, count unchanged.
- clear has priority over push and pop in the same cycle. It sets both pointers to 0 and overrun to 0, and forces rd_valid to 0 on the next cycle. A push presented in the clear cycle is discarded.
- overrun is cleared only by clear or reset.
- No state machine beyond the pointer/flag registers. Wrap-around is natural overflow of the pointers.

## Timing
- Reset values: rd_data 8'h00, rd_parity_err 0, rd_valid 0, empty 1, full 0, count 0, overrun 0, irq 0; pointers 0.
- Write: the entry is written on the accepting edge. empty/full/count reflect it on the cycle after the push.
- Read latency is 1. On an accepting edge, rd_data/rd_parity_err register the entry at rd_ptr and rd_valid = 1 for exactly one cycle. Back-to-back rd_en gives back-to-back rd_valid.
- rd_data holds its last value when rd_valid = 0.
- rx_valid is a strobe. Each high cycle is one push request, so a receiver holding rx_valid high for N cycles gives N pushes.
- Status outputs (empty, full, count, overrun, irq) are registered or derived from registered state only. There are no combinational paths from inputs to outputs.

## Configuration
- UART_RX_FIFO_IRQ_EN defined:
  - irq_thresh and irq ports exist.
  - irq = registered (count >= irq_thresh) || overrun, updated every cycle.
  - irq_thresh = 0 gives a permanently asserted irq.
- UART_RX_FIFO_IRQ_EN undefined: the ports and logic are absent, and all other behaviour is identical.

## Structure
- Package uart_rx_fifo_pkg holds:
  - typedef rx_entry_t, a packed struct {logic parity_err; logic [7:0] data}.
  - localparam UART_RX_FIFO_DEFAULT_DEPTH = 16.
- One sub-module, uart_fifo_ram: DEPTH × rx_entry_t register array with a synchronous write port and an asynchronous read at an index. The top registers the read output.

## Test plan
- After reset, push 8'hA5 (parity ok), then pop → empty drops the cycle after the push. One cycle after rd_en: rd_valid = 1, rd_data = 8'hA5, rd_parity_err = 0. empty = 1 again.
- Push 8'h3C with rx_parity_ok = 0, then pop → rd_data = 8'h3C, rd_parity_err = 1.
- Push 17 bytes 8'h00..8'h10 with DEPTH = 16 and no pops → full = 1, count = 16, overrun = 1. Popping 16 times returns 8'h00..8'h0F in order, and 8'h10 never appears.
- When full, assert rx_valid (8'h77) and rd_en together → count stays 16, overrun stays 0. The 16th subsequent pop returns 8'h77, exercising pointer wrap.
- With 5 entries stored, assert clear together with rx_valid and rd_en → next cycle count = 0, empty = 1, overrun = 0, rd_valid = 0.
- With UART_RX_FIFO_IRQ_EN, irq_thresh = 4: push 3 bytes → irq = 0. Push a 4th → irq = 1. Pop 1 → irq = 0.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// ============================================================================
// uart_rx_fifo_pkg : shared entry type and defaults for the UART RX FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_rx_fifo_pkg;

  localparam int UART_RX_FIFO_DEFAULT_DEPTH = 16;

  typedef struct packed {
    logic       parity_err;
    logic [7:0] data;
  } rx_entry_t;

endpackage

`default_nettype wire

// File: rtl/uart_fifo_ram.sv
// ============================================================================
// uart_fifo_ram : DEPTH x rx_entry_t register array, sync write, async read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_fifo_ram
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  rx_entry_t                wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output rx_entry_t                rdata_o
);

  rx_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// uart_rx_fifo : receive buffer behind the UART receiver, 1-cycle pop latency.
// Optional level interrupt enabled by defining UART_RX_FIFO_IRQ_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_parity_ok,
  input  logic                   rd_en,
  input  logic                   clear,
  output logic [7:0]             rd_data,
  output logic                   rd_parity_err,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun
`ifdef UART_RX_FIFO_IRQ_EN
  ,
  input  logic [$clog2(DEPTH):0] irq_thresh,
  output logic                   irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overrun_q, overrun_d;
  logic          rd_valid_q, rd_valid_d;
  rx_entry_t     rd_entry_q, rd_entry_d;
  rx_entry_t     ram_rdata;
  rx_entry_t     wr_entry;
  logic          pop_ok;
  logic          push_ok;
  logic          ram_we;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign pop_ok  = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign push_ok = rx_valid && (!full || pop_ok);
  assign ram_we  = push_ok && !clear;
  assign wr_entry = '{parity_err: ~rx_parity_ok, data: rx_data};

  uart_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overrun_d  = overrun_q;
    rd_valid_d = 1'b0;
    rd_entry_d = rd_entry_q;
    if (clear) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      overrun_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok) begin
        rd_ptr_d   = rd_ptr_q + PW'(1);
        rd_valid_d = 1'b1;
        rd_entry_d = ram_rdata;
      end
      if (rx_valid && !push_ok) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overrun_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_entry_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overrun_q  <= overrun_d;
      rd_valid_q <= rd_valid_d;
      rd_entry_q <= rd_entry_d;
    end
  end

  assign rd_data       = rd_entry_q.data;
  assign rd_parity_err = rd_entry_q.parity_err;
  assign rd_valid      = rd_valid_q;
  assign overrun       = overrun_q;

`ifdef UART_RX_FIFO_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (count >= irq_thresh) || overrun_q;
    end
  end

  assign irq = irq_q;
`endif

endmodule

`default_nettype wire
